mul_div_unit: RTL and testbench

//  Multi-cycle multiply/divide unit in EX. Feeds the HI/LO register pair.

---
 rtl/mul_div_unit.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_mul_div_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle multiply/divide unit for the EX stage.
// Produces write pulses and data for the HI/LO register pair.
//   MULT/MULTU : IDLE -> MUL -> WB, pulse two cycles after accept.
//   DIV/DIVU   : IDLE -> DIV (32 restoring iterations) -> WB, pulse 33 cycles after accept.
//   MTHI/MTLO  : IDLE -> WB, single-enable pulse one cycle after accept.
// Optional feature macro MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU
// (accumulate into the latched {cur_hi,cur_lo}); without it ops 6-9 are ignored.
module mul_div_unit #(
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [3:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [31:0] cur_hi,
  input  logic [31:0] cur_lo,
  input  logic        flush,
  output logic        busy,
  output logic        hi_we,
  output logic        lo_we,
  output logic [31:0] wd_hi,
  output logic [31:0] wd_lo
);

  localparam int CNT_W = $clog2(DIV_ITER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_WB
  } state_e;

  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_MTHI  = 4'd4,
    OP_MTLO  = 4'd5,
    OP_MADD  = 4'd6,
    OP_MADDU = 4'd7,
    OP_MSUB  = 4'd8,
    OP_MSUBU = 4'd9
  } op_e;

  // State and datapath registers
  state_e           state_q, state_d;
  logic [31:0]      op_a_q, op_a_d;       // raw multiplicand / dividend
  logic [31:0]      op_b_q, op_b_d;       // raw multiplier
  logic             mul_signed_q, mul_signed_d;
  logic [31:0]      rem_q, rem_d;         // partial remainder
  logic [31:0]      quo_q, quo_d;         // dividend magnitude shifting into quotient
  logic [31:0]      dvsr_q, dvsr_d;       // divisor magnitude
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             div_zero_q, div_zero_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hi_we_q, hi_we_d;
  logic             lo_we_q, lo_we_d;
  logic [31:0]      wd_hi_q, wd_hi_d;
  logic [31:0]      wd_lo_q, wd_lo_d;
`ifdef MDU_MADD_EN
  logic [63:0]      acc_q, acc_d;
  logic             acc_en_q, acc_en_d;
  logic             acc_sub_q, acc_sub_d;
`endif

  // Decoded op
  logic dec_legal, dec_signed, dec_mul, dec_div, dec_mthi, dec_mtlo;
`ifdef MDU_MADD_EN
  logic dec_acc, dec_sub;
`endif
  logic accept;

  // Datapath nets
  logic [31:0] a_mag, b_mag;
  logic [63:0] mul_a_ext, mul_b_ext, product, mul_result;
  logic [32:0] rem_shift, rem_diff;
  logic        step_ok;
  logic [31:0] rem_next, quo_next, quo_final, rem_final;

  // Op decode: classify the presented op and flag illegal codes.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    dec_legal  = 1'b0;
    dec_signed = 1'b0;
    dec_mul    = 1'b0;
    dec_div    = 1'b0;
    dec_mthi   = 1'b0;
    dec_mtlo   = 1'b0;
`ifdef MDU_MADD_EN
    dec_acc    = 1'b0;
    dec_sub    = 1'b0;
`endif
    case (op)
      OP_MULT:  begin dec_legal = 1'b1; dec_mul = 1'b1; dec_signed = 1'b1; end
      OP_MULTU: begin dec_legal = 1'b1; dec_mul = 1'b1; end
      OP_DIV:   begin dec_legal = 1'b1; dec_div = 1'b1; dec_signed = 1'b1; end
      OP_DIVU:  begin dec_legal = 1'b1; dec_div = 1'b1; end
      OP_MTHI:  begin dec_legal = 1'b1; dec_mthi = 1'b1; end
      OP_MTLO:  begin dec_legal = 1'b1; dec_mtlo = 1'b1; end
`ifdef MDU_MADD_EN
      OP_MADD:  begin dec_legal = 1'b1; dec_mul = 1'b1; dec_acc = 1'b1; dec_signed = 1'b1; end
      OP_MADDU: begin dec_legal = 1'b1; dec_mul = 1'b1; dec_acc = 1'b1; end
      OP_MSUB:  begin dec_legal = 1'b1; dec_mul = 1'b1; dec_acc = 1'b1; dec_sub = 1'b1;
                      dec_signed = 1'b1; end
      OP_MSUBU: begin dec_legal = 1'b1; dec_mul = 1'b1; dec_acc = 1'b1; dec_sub = 1'b1; end
`endif
      default:  ;
    endcase
  end

  assign accept = op_valid && (state_q == S_IDLE) && !flush && dec_legal;

`ifndef MDU_MADD_EN
  // Accumulator inputs have no consumer when the accumulate ops are disabled.
  logic unused_acc_inputs;
  assign unused_acc_inputs = ^{cur_hi, cur_lo};
`endif

  // Multiply / accumulate and one restoring-divide step.
  always_comb begin
    a_mag = (dec_signed && src_a[31]) ? -src_a : src_a;
    b_mag = (dec_signed && src_b[31]) ? -src_b : src_b;

    mul_a_ext = mul_signed_q ? {{32{op_a_q[31]}}, op_a_q} : {32'b0, op_a_q};
    mul_b_ext = mul_signed_q ? {{32{op_b_q[31]}}, op_b_q} : {32'b0, op_b_q};
    product   = mul_a_ext * mul_b_ext;
`ifdef MDU_MADD_EN
    if (acc_en_q) begin
      mul_result = acc_sub_q ? (acc_q - product) : (acc_q + product);
    end else begin
      mul_result = product;
    end
`else
    mul_result = product;
`endif

    // Remainder stays below the divisor, so a 33-bit shift/subtract is exact.
    rem_shift = {rem_q, quo_q[31]};
    rem_diff  = rem_shift - {1'b0, dvsr_q};
    step_ok   = !rem_diff[32];
    rem_next  = step_ok ? rem_diff[31:0] : rem_shift[31:0];
    quo_next  = {quo_q[30:0], step_ok};

    if (div_zero_q) begin
      quo_final = 32'hFFFF_FFFF;
      rem_final = op_a_q;
    end else begin
      quo_final = neg_quo_q ? -quo_next : quo_next;
      rem_final = neg_rem_q ? -rem_next : rem_next;
    end
  end

  // Next-state and registered-output logic for the IDLE/MUL/DIV/WB controller.
  always_comb begin
    state_d      = state_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    mul_signed_d = mul_signed_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    dvsr_d       = dvsr_q;
    neg_quo_d    = neg_quo_q;
    neg_rem_d    = neg_rem_q;
    div_zero_d   = div_zero_q;
    cnt_d        = cnt_q;
    hi_we_d      = 1'b0;
    lo_we_d      = 1'b0;
    wd_hi_d      = wd_hi_q;
    wd_lo_d      = wd_lo_q;
`ifdef MDU_MADD_EN
    acc_d        = acc_q;
    acc_en_d     = acc_en_q;
    acc_sub_d    = acc_sub_q;
`endif

    if (flush) begin
      // Drop whatever is in flight; a pulse already on the outputs is unaffected.
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_a_d       = src_a;
            op_b_d       = src_b;
            mul_signed_d = dec_signed;
`ifdef MDU_MADD_EN
            acc_d        = {cur_hi, cur_lo};
            acc_en_d     = dec_acc;
            acc_sub_d    = dec_sub;
`endif
            if (dec_mthi) begin
              wd_hi_d = src_a;
              hi_we_d = 1'b1;
              state_d = S_WB;
            end else if (dec_mtlo) begin
              wd_lo_d = src_a;
              lo_we_d = 1'b1;
              state_d = S_WB;
            end else if (dec_mul) begin
              state_d = S_MUL;
            end else if (dec_div) begin
              rem_d      = '0;
              quo_d      = a_mag;
              dvsr_d     = b_mag;
              neg_quo_d  = dec_signed && (src_a[31] ^ src_b[31]);
              neg_rem_d  = dec_signed && src_a[31];
              div_zero_d = (src_b == 32'd0);
              cnt_d      = '0;
              state_d    = S_DIV;
            end
          end
        end
        S_MUL: begin
          {wd_hi_d, wd_lo_d} = mul_result;
          hi_we_d = 1'b1;
          lo_we_d = 1'b1;
          state_d = S_WB;
        end
        S_DIV: begin
          rem_d = rem_next;
          quo_d = quo_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            wd_lo_d = quo_final;
            wd_hi_d = rem_final;
            hi_we_d = 1'b1;
            lo_we_d = 1'b1;
            cnt_d   = '0;
            state_d = S_WB;
          end
        end
        S_WB: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      op_a_q       <= '0;
      op_b_q       <= '0;
      mul_signed_q <= 1'b0;
      rem_q        <= '0;
      quo_q        <= '0;
      dvsr_q       <= '0;
      neg_quo_q    <= 1'b0;
      neg_rem_q    <= 1'b0;
      div_zero_q   <= 1'b0;
      cnt_q        <= '0;
      hi_we_q      <= 1'b0;
      lo_we_q      <= 1'b0;
      wd_hi_q      <= '0;
      wd_lo_q      <= '0;
`ifdef MDU_MADD_EN
      acc_q        <= '0;
      acc_en_q     <= 1'b0;
      acc_sub_q    <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      mul_signed_q <= mul_signed_d;
      rem_q        <= rem_d;
      quo_q        <= quo_d;
      dvsr_q       <= dvsr_d;
      neg_quo_q    <= neg_quo_d;
      neg_rem_q    <= neg_rem_d;
      div_zero_q   <= div_zero_d;
      cnt_q        <= cnt_d;
      hi_we_q      <= hi_we_d;
      lo_we_q      <= lo_we_d;
      wd_hi_q      <= wd_hi_d;
      wd_lo_q      <= wd_lo_d;
`ifdef MDU_MADD_EN
      acc_q        <= acc_d;
      acc_en_q     <= acc_en_d;
      acc_sub_q    <= acc_sub_d;
`endif
    end
  end

  assign busy  = (state_q != S_IDLE);
  assign hi_we = hi_we_q;
  assign lo_we = lo_we_q;
  assign wd_hi = wd_hi_q;
  assign wd_lo = wd_lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: table-driven check of mul_div_unit plus hand-written
// sequences for busy-ignore, flush, back-to-back issue and mid-operation reset.
// Define MDU_MADD_EN for both bench and RTL to exercise the accumulate ops.
module tb_mul_div_unit;

  localparam logic [3:0] MULT  = 4'd0;
  localparam logic [3:0] MULTU = 4'd1;
  localparam logic [3:0] DIV   = 4'd2;
  localparam logic [3:0] DIVU  = 4'd3;
  localparam logic [3:0] MTHI  = 4'd4;
  localparam logic [3:0] MTLO  = 4'd5;
  localparam logic [3:0] MADD  = 4'd6;
  localparam logic [3:0] MADDU = 4'd7;
  localparam logic [3:0] MSUB  = 4'd8;

  logic        clk = 1'b0;
  logic        reset, op_valid, flush;
  logic [3:0]  op;
  logic [31:0] src_a, src_b, cur_hi, cur_lo;
  logic        busy, hi_we, lo_we;
  logic [31:0] wd_hi, wd_lo;

  int tests = 0;
  int fails = 0;

  mul_div_unit dut (
    .clk      (clk),
    .reset    (reset),
    .op_valid (op_valid),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .cur_hi   (cur_hi),
    .cur_lo   (cur_lo),
    .flush    (flush),
    .busy     (busy),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .wd_hi    (wd_hi),
    .wd_lo    (wd_lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic        hwe;
    logic        lwe;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic present(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1;
    op       = o;
    src_a    = a;
    src_b    = b;
  endtask

  // Counts cycles with any write enable over the next n cycles.
  task automatic watch(input int n, output int pulses);
    pulses = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (hi_we || lo_we) pulses++;
    end
  endtask

  // Issue one op, wait (bounded) for its pulse and check latency, enables and data.
  task automatic run_vec(input string tag, input vec_t v);
    int cyc;
    @(negedge clk);
    present(v.op, v.a, v.b);
    @(negedge clk);
    op_valid = 1'b0;
    check({tag, "_busy_t1"}, busy, 1);
    cyc = 1;
    while (!(hi_we || lo_we) && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, cyc, v.lat);
    check({tag, "_busy_wb"}, busy, 1);
    check({tag, "_hi_we"}, hi_we, v.hwe);
    check({tag, "_lo_we"}, lo_we, v.lwe);
    if (v.hwe) check({tag, "_wd_hi"}, wd_hi, v.hi);
    if (v.lwe) check({tag, "_wd_lo"}, wd_lo, v.lo);
    @(negedge clk);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_we_after"}, {hi_we, lo_we}, 2'b00);
  endtask

  initial begin
    int p, first;
    logic [31:0] cap_hi, cap_lo;

    //            op     a             b             lat hwe   lwe   hi            lo
    vecs[0]  = '{MULT,  32'hFFFFFFFD, 32'd5,        2, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[1]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, 1'b1, 1'b1, 32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{MULT,  32'h80000000, 32'h80000000, 2, 1'b1, 1'b1, 32'h40000000, 32'h00000000};
    vecs[3]  = '{MULTU, 32'h12345678, 32'h10,       2, 1'b1, 1'b1, 32'h00000001, 32'h23456780};
    vecs[4]  = '{MULT,  32'h7FFFFFFF, 32'hFFFFFFFF, 2, 1'b1, 1'b1, 32'hFFFFFFFF, 32'h80000001};
    vecs[5]  = '{DIVU,  32'd100,      32'd7,        33, 1'b1, 1'b1, 32'd2,       32'd14};
    vecs[6]  = '{DIV,   32'hFFFFFFF9, 32'd2,        33, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[7]  = '{DIV,   32'd7,        32'hFFFFFFFE, 33, 1'b1, 1'b1, 32'd1,       32'hFFFFFFFD};
    vecs[8]  = '{DIV,   32'd9,        32'd0,        33, 1'b1, 1'b1, 32'd9,       32'hFFFFFFFF};
    vecs[9]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 33, 1'b1, 1'b1, 32'd0,       32'h80000000};
    vecs[10] = '{DIVU,  32'hFFFFFFFF, 32'd0,        33, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[11] = '{DIV,   32'hFFFFFFF8, 32'd0,        33, 1'b1, 1'b1, 32'hFFFFFFF8, 32'hFFFFFFFF};
    vecs[12] = '{DIVU,  32'hFFFFFFFF, 32'h10,       33, 1'b1, 1'b1, 32'hF,       32'h0FFFFFFF};
    vecs[13] = '{DIVU,  32'h80000000, 32'hFFFFFFFF, 33, 1'b1, 1'b1, 32'h80000000, 32'd0};
    vecs[14] = '{DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 33, 1'b1, 1'b1, 32'hFFFFFFFF, 32'd3};
    vecs[15] = '{MTHI,  32'hDEADBEEF, 32'd0,        1, 1'b1, 1'b0, 32'hDEADBEEF, 32'd0};
    vecs[16] = '{MTLO,  32'hCAFEF00D, 32'd0,        1, 1'b0, 1'b1, 32'd0,       32'hCAFEF00D};

    // Reset state
    reset = 1'b1; op_valid = 1'b0; flush = 1'b0; op = 4'd0;
    src_a = '0; src_b = '0; cur_hi = 32'hAAAA5555; cur_lo = 32'h5555AAAA;
    @(negedge clk);
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_we", {hi_we, lo_we}, 2'b00);
    check("reset_wd", {wd_hi, wd_lo}, 64'd0);
    reset = 1'b0;

    // Table of single operations
    for (int i = 0; i < 17; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // DIVU 100/7 with a MULT presented at T+5 while busy: exactly one write at T+33
    @(negedge clk);
    present(DIVU, 32'd100, 32'd7);
    p = 0; first = 0; cap_hi = '0; cap_lo = '0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (hi_we || lo_we) begin
        p++;
        if (first == 0) begin
          first = c; cap_hi = wd_hi; cap_lo = wd_lo;
        end
      end
      if (c == 1) op_valid = 1'b0;
      if (c == 5) present(MULT, 32'd3, 32'd4);
      if (c == 6) op_valid = 1'b0;
    end
    check("busy_ignore_pulses", p, 1);
    check("busy_ignore_latency", first, 33);
    check("busy_ignore_wd_lo", cap_lo, 32'd14);
    check("busy_ignore_wd_hi", cap_hi, 32'd2);

    // Flush a DIVU at T+10, then MTLO at T+11
    @(negedge clk);
    present(DIVU, 32'd1000, 32'd3);
    p = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (hi_we || lo_we) p++;
      if (c == 1) op_valid = 1'b0;
      if (c == 10) flush = 1'b1;
    end
    check("flush_div_no_pulse", p, 0);
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy_t11", busy, 0);
    present(MTLO, 32'h1234, 32'd0);
    @(negedge clk);
    op_valid = 1'b0;
    check("flush_mtlo_lo_we", lo_we, 1);
    check("flush_mtlo_hi_we", hi_we, 0);
    check("flush_mtlo_wd_lo", wd_lo, 32'h1234);
    watch(40, p);
    check("flush_div_dropped", p, 0);

    // A fresh divide after a flush keeps full latency
    run_vec("post_flush_div", vecs[5]);

    // Flush during MUL: no write
    @(negedge clk);
    present(MULT, 32'd6, 32'd7);
    @(negedge clk);
    op_valid = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_mul_busy", busy, 0);
    check("flush_mul_we", {hi_we, lo_we}, 2'b00);
    watch(5, p);
    check("flush_mul_no_pulse", p, 0);

    // Flush in the WB cycle keeps the pulse; back-to-back issue right after
    @(negedge clk);
    present(MTHI, 32'h55, 32'd0);
    @(negedge clk);
    op_valid = 1'b0;
    flush = 1'b1;
    check("wb_flush_hi_we", hi_we, 1);
    check("wb_flush_wd_hi", wd_hi, 32'h55);
    @(negedge clk);
    flush = 1'b0;
    check("wb_flush_busy_after", busy, 0);
    present(MTLO, 32'h77, 32'd0);
    @(negedge clk);
    op_valid = 1'b0;
    check("b2b_lo_we", {hi_we, lo_we}, 2'b01);
    check("b2b_wd_lo", wd_lo, 32'h77);
    check("b2b_wd_hi_hold", wd_hi, 32'h55);
    @(negedge clk);

`ifdef MDU_MADD_EN
    cur_hi = 32'd1; cur_lo = 32'hFFFFFFFF;
    run_vec("maddu", '{MADDU, 32'd2, 32'd3, 2, 1'b1, 1'b1, 32'd2, 32'd5});
    cur_hi = 32'd0; cur_lo = 32'd0;
    run_vec("msub", '{MSUB, 32'd2, 32'd3, 2, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA});
    cur_hi = 32'hFFFFFFFF; cur_lo = 32'hFFFFFFFF;
    run_vec("madd", '{MADD, 32'hFFFFFFFE, 32'd3, 2, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF9});
    cur_hi = 32'hAAAA5555; cur_lo = 32'h5555AAAA;
`else
    // MADD is illegal in the default build
    @(negedge clk);
    present(MADD, 32'd2, 32'd3);
    @(negedge clk);
    op_valid = 1'b0;
    check("madd_illegal_busy", busy, 0);
    watch(5, p);
    check("madd_illegal_no_pulse", p, 0);
`endif

    // Opcode 15 is never legal
    @(negedge clk);
    present(4'd15, 32'd2, 32'd3);
    @(negedge clk);
    op_valid = 1'b0;
    check("op15_illegal_busy", busy, 0);
    watch(5, p);
    check("op15_illegal_no_pulse", p, 0);

    // Reset mid-divide: outputs back to reset values, op abandoned
    @(negedge clk);
    present(DIVU, 32'd50, 32'd3);
    @(negedge clk);
    op_valid = 1'b0;
    watch(4, p);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_busy", busy, 0);
    check("midreset_we", {hi_we, lo_we}, 2'b00);
    check("midreset_wd", {wd_hi, wd_lo}, 64'd0);
    watch(40, p);
    check("midreset_no_pulse", p, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
